// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
// Per-register busy scoreboard between ID decode and the pipeline control
// registers. Loads hold their rd busy for LOAD_LAT cycles after issue.
// Long-latency ops (MUL/DIV) hold their rd busy until their writeback.
// RAW and WAW hazards against busy entries raise stall/bubble.
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   id_valid                          ID holds a valid instruction
//   id_rs1/_re, id_rs2/_re            source addresses and read enables
//   id_rd/id_rd_we                    destination address and write enable
//   id_load, id_long                  producer class (mutually exclusive)
//   flush                             ID instruction killed this cycle
//   wb_valid, wb_rd                   long-op writeback
//   stall, bubble                     hold PC/IF_ID, insert NOP into ID_EX
//   long_pending                      at least one long-op entry is busy
//   stall_cnt                         saturating count of stall cycles
module hazard_scoreboard #(
  parameter int REG_NUM   = 32,
  parameter int ADDR_W    = 5,
  parameter int LOAD_LAT  = 1,
  parameter int WB_BYPASS = 1,
  parameter int CNT_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_rs1,
  input  logic              id_rs1_re,
  input  logic [ADDR_W-1:0] id_rs2,
  input  logic              id_rs2_re,
  input  logic [ADDR_W-1:0] id_rd,
  input  logic              id_rd_we,
  input  logic              id_load,
  input  logic              id_long,
  input  logic              flush,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_rd,
  output logic              stall,
  output logic              bubble,
  output logic              long_pending,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int   CW           = $clog2(LOAD_LAT + 1);
  localparam int   ADDR_SPAN    = 1 << ADDR_W;
  localparam logic WB_BYPASS_EN = (WB_BYPASS != 0);

  // Entry 0 (x0) is never tracked, so state starts at index 1.
  logic [REG_NUM-1:1] busy_reg;
  logic [REG_NUM-1:1] lng_reg;
  logic [CW-1:0]      cnt_reg [1:REG_NUM-1];
  logic [CNT_W-1:0]   stall_cnt_reg;

  // Effective busy over the whole address space: x0 and addresses past
  // REG_NUM read as free, so the lookups below never index out of range.
  logic [ADDR_SPAN-1:0] eb_ext;

  genvar gi;
  generate
    for (gi = 0; gi < ADDR_SPAN; gi++) begin : g_eb
      if (gi >= 1 && gi < REG_NUM) begin : g_trk
        assign eb_ext[gi] = busy_reg[gi] &
                            ~(WB_BYPASS_EN & wb_valid & lng_reg[gi] &
                              (wb_rd == ADDR_W'(gi)));
      end else begin : g_none
        assign eb_ext[gi] = 1'b0;
      end
    end
  endgenerate

  logic raw1, raw2, waw, issue;

  always_comb begin
    raw1  = id_rs1_re & eb_ext[id_rs1];
    raw2  = id_rs2_re & eb_ext[id_rs2];
    waw   = id_rd_we  & eb_ext[id_rd];
    stall = id_valid & ~flush & (raw1 | raw2 | waw);
    issue = id_valid & ~flush & ~stall & id_rd_we & (id_rd != '0) &
            (id_load | id_long);
  end

  assign bubble       = stall;
  assign long_pending = |(busy_reg & lng_reg);
  assign stall_cnt    = stall_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_reg      <= '0;
      lng_reg       <= '0;
      stall_cnt_reg <= '0;
      for (int r = 1; r < REG_NUM; r++) begin
        cnt_reg[r] <= '0;
      end
    end else begin
      for (int r = 1; r < REG_NUM; r++) begin
        // A new issue to r wins over any same-cycle retirement of r.
        if (issue && id_rd == ADDR_W'(r)) begin
          busy_reg[r] <= 1'b1;
          if (id_load) begin
            lng_reg[r] <= 1'b0;
            cnt_reg[r] <= CW'(LOAD_LAT);
          end else begin
            lng_reg[r] <= 1'b1;
          end
        end else if (busy_reg[r] && !lng_reg[r]) begin
          if (cnt_reg[r] == CW'(1)) begin
            busy_reg[r] <= 1'b0;
            cnt_reg[r]  <= '0;
          end else begin
            cnt_reg[r] <= cnt_reg[r] - CW'(1);
          end
        end else if (busy_reg[r] && lng_reg[r] && wb_valid &&
                     wb_rd == ADDR_W'(r)) begin
          busy_reg[r] <= 1'b0;
          lng_reg[r]  <= 1'b0;
        end
      end
      if (stall && stall_cnt_reg != '1) begin
        stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard
// Directed bench. Four scoreboards with different parameters share one
// stimulus stream; each scenario checks the instance whose parameters it
// exercises. Inputs change 1 time unit after the rising edge and outputs
// are sampled 1 time unit later, away from the edge.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs1;
  logic       id_rs1_re;
  logic [4:0] id_rs2;
  logic       id_rs2_re;
  logic [4:0] id_rd;
  logic       id_rd_we;
  logic       id_load;
  logic       id_long;
  logic       flush;
  logic       wb_valid;
  logic [4:0] wb_rd;

  logic        s1, b1, lp1;
  logic [31:0] c1;
  logic        s3, b3, lp3;
  logic [31:0] c3;
  logic        s0, b0, lp0;
  logic [31:0] c0;
  logic        s4, b4, lp4;
  logic [3:0]  c4;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Default parameters: LOAD_LAT=1, WB_BYPASS=1, CNT_W=32.
  hazard_scoreboard u_d1 (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs1_re(id_rs1_re), .id_rs2(id_rs2), .id_rs2_re(id_rs2_re),
    .id_rd(id_rd), .id_rd_we(id_rd_we), .id_load(id_load), .id_long(id_long),
    .flush(flush), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .stall(s1), .bubble(b1), .long_pending(lp1), .stall_cnt(c1)
  );

  hazard_scoreboard #(.LOAD_LAT(3)) u_d3 (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs1_re(id_rs1_re), .id_rs2(id_rs2), .id_rs2_re(id_rs2_re),
    .id_rd(id_rd), .id_rd_we(id_rd_we), .id_load(id_load), .id_long(id_long),
    .flush(flush), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .stall(s3), .bubble(b3), .long_pending(lp3), .stall_cnt(c3)
  );

  hazard_scoreboard #(.WB_BYPASS(0)) u_d0 (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs1_re(id_rs1_re), .id_rs2(id_rs2), .id_rs2_re(id_rs2_re),
    .id_rd(id_rd), .id_rd_we(id_rd_we), .id_load(id_load), .id_long(id_long),
    .flush(flush), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .stall(s0), .bubble(b0), .long_pending(lp0), .stall_cnt(c0)
  );

  hazard_scoreboard #(.CNT_W(4)) u_d4 (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs1_re(id_rs1_re), .id_rs2(id_rs2), .id_rs2_re(id_rs2_re),
    .id_rd(id_rd), .id_rd_we(id_rd_we), .id_load(id_load), .id_long(id_long),
    .flush(flush), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .stall(s4), .bubble(b4), .long_pending(lp4), .stall_cnt(c4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs1_re = 0; id_rs2 = 0; id_rs2_re = 0;
    id_rd = 0; id_rd_we = 0; id_load = 0; id_long = 0;
    flush = 0; wb_valid = 0; wb_rd = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick();
    rst = 0;
  endtask

  // Drive a producer into ID (load when is_load, else long op).
  task automatic producer(input logic [4:0] rd, input logic is_load);
    idle();
    id_valid = 1; id_rd = rd; id_rd_we = 1;
    id_load = is_load; id_long = ~is_load;
  endtask

  task automatic consumer(input logic [4:0] rs1, input logic re1,
                          input logic [4:0] rs2, input logic re2);
    idle();
    id_valid = 1; id_rs1 = rs1; id_rs1_re = re1; id_rs2 = rs2; id_rs2_re = re2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    rst = 1;
    tick();
    tick();
    rst = 0;
    #1;
    chk("reset_stall", 32'(s1), 0);
    chk("reset_bubble", 32'(b1), 0);
    chk("reset_long_pending", 32'(lp1), 0);
    chk("reset_stall_cnt", c1, 0);

    // Load-use with LOAD_LAT=1 (u_d1) and LOAD_LAT=3 (u_d3), rs2 consumer.
    do_reset();
    producer(5'd7, 1'b1);
    #1 chk("load_issue_no_stall", 32'(s1), 0);
    tick();
    consumer(5'd0, 1'b0, 5'd7, 1'b1);
    for (int c = 1; c <= 3; c++) begin
      #1;
      chk($sformatf("lat3_stall_c%0d", c), 32'(s3), 1);
      if (c == 1) begin
        chk("lat1_stall_c1", 32'(s1), 1);
        chk("lat1_bubble_c1", 32'(b1), 1);
      end
      tick();
    end
    #1;
    chk("lat3_released", 32'(s3), 0);
    chk("lat3_stall_cnt", c3, 3);
    chk("lat1_released", 32'(s1), 0);
    chk("lat1_stall_cnt", c1, 1);

    // False hazards: rd=0 load then rs1=0; rd=4 load then rs2=4 unread.
    do_reset();
    producer(5'd0, 1'b1);
    tick();
    consumer(5'd0, 1'b1, 5'd0, 1'b0);
    #1 chk("x0_no_stall", 32'(s3), 0);
    tick();
    producer(5'd4, 1'b1);
    tick();
    consumer(5'd0, 1'b0, 5'd4, 1'b0);
    #1 chk("rs2_unread_no_stall", 32'(s3), 0);
    tick();
    tick();
    chk("false_hazard_stall_cnt", c3, 0);

    // Long op rd=9, writeback at cycle 12; bypass (u_d1) vs none (u_d0).
    do_reset();
    producer(5'd9, 1'b0);
    tick();
    consumer(5'd9, 1'b1, 5'd0, 1'b0);
    for (int c = 1; c <= 11; c++) begin
      #1;
      if (s1 !== 1'b1 || s0 !== 1'b1) chk($sformatf("long_stall_c%0d", c), 32'({s1, s0}), 3);
      tick();
    end
    chk("long_pending_c11", 32'(lp1), 1);
    wb_valid = 1; wb_rd = 5'd9;
    #1;
    chk("bypass_c12_stall", 32'(s1), 0);
    chk("nobypass_c12_stall", 32'(s0), 1);
    chk("long_pending_c12", 32'(lp1), 1);
    tick();
    wb_valid = 0; wb_rd = 0;
    #1;
    chk("long_pending_after_wb", 32'(lp1), 0);
    chk("nobypass_long_pending_after_wb", 32'(lp0), 0);
    chk("nobypass_released", 32'(s0), 0);
    chk("bypass_stall_cnt", c1, 11);
    chk("nobypass_stall_cnt", c0, 12);

    // WAW against a pending DIV rd=3, then flush in a stall cycle.
    do_reset();
    producer(5'd3, 1'b0);
    tick();
    producer(5'd3, 1'b1);
    #1 chk("waw_stall", 32'(s1), 1);
    tick();
    flush = 1;
    #1 chk("flush_stall", 32'(s1), 0);
    chk("flush_bubble", 32'(b1), 0);
    tick();
    flush = 0;
    wb_valid = 1; wb_rd = 5'd0;  // writeback to x0 is ignored
    #1 chk("flush_no_issue_long_pending", 32'(lp1), 1);
    chk("entry3_still_busy", 32'(s1), 1);
    tick();
    idle();
    wb_valid = 1; wb_rd = 5'd3;
    tick();
    wb_valid = 0;
    #1 chk("waw_cleared", 32'(lp1), 0);

    // Reset while a DIV is outstanding.
    do_reset();
    producer(5'd9, 1'b0);
    tick();
    consumer(5'd9, 1'b1, 5'd0, 1'b0);
    #1 chk("pre_reset_stall", 32'(s1), 1);
    rst = 1;
    tick();
    rst = 0;
    #1;
    chk("post_reset_stall", 32'(s1), 0);
    chk("post_reset_long_pending", 32'(lp1), 0);

    // Saturation: 20 stall cycles on a CNT_W=4 counter.
    do_reset();
    producer(5'd2, 1'b0);
    tick();
    consumer(5'd2, 1'b1, 5'd0, 1'b0);
    for (int c = 0; c < 20; c++) tick();
    chk("sat_stall_cnt_w4", 32'(c4), 15);
    chk("unsat_stall_cnt_w32", c1, 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the single-cycle load-use detector.
- Per-register busy scoreboard. Each entry is marked busy when a producing instruction leaves ID:
  - loads, with a fixed latency;
  - long-latency ops (MUL/DIV), until their writeback.
- Generates the PC / IF_ID stall and the ID_EX bubble for RAW and WAW hazards, and keeps a saturating stall-cycle counter.
- Sits between ID decode and the pipeline control registers.

Parameters:
- REG_NUM, 32, number of architectural registers; x0 is never tracked.
- ADDR_W, 5, register address width; must satisfy 2^ADDR_W >= REG_NUM.
- LOAD_LAT, 1, cycles a load's rd stays busy after issue; must be >= 1. Value 1 reproduces the classic one-bubble load-use stall.
- WB_BYPASS, 1, when 1 a writeback in the current cycle un-busies its rd combinationally.
- CNT_W, 32, stall counter width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  ID stage holds a valid instruction
- id_rs1  in  ADDR_W  source 1 address
- id_rs1_re  in  1  source 1 is actually read
- id_rs2  in  ADDR_W  source 2 address
- id_rs2_re  in  1  source 2 is actually read
- id_rd  in  ADDR_W  destination address
- id_rd_we  in  1  instruction writes rd
- id_load  in  1  instruction is a load
- id_long  in  1  instruction is a long-latency op; id_load and id_long are mutually exclusive
- flush  in  1  ID instruction is being killed this cycle (branch/jump)
- wb_valid  in  1  long-op writeback this cycle
- wb_rd  in  ADDR_W  long-op writeback destination
- stall  out  1  hold PC and IF_ID
- bubble  out  1  insert NOP into ID_EX
- long_pending  out  1  at least one long-op entry busy
- stall_cnt  out  CNT_W  cycles with stall asserted, saturating

Behaviour:
- State per entry r in 1..REG_NUM-1:
  - busy[r];
  - lng[r], which marks a long-op entry;
  - cnt[r], width clog2(LOAD_LAT+1).
- Reset: all busy, lng and cnt cleared; stall_cnt = 0. Outputs on the cycle after a reset cycle: stall = bubble = long_pending = 0.
- Effective busy, eb(r):
  - always 0 for r = 0;
  - otherwise busy[r] & ~(WB_BYPASS & wb_valid & lng[r] & wb_rd == r).
- Hazard terms (all combinational from registered state plus current inputs):
  - raw1 = id_rs1_re & eb(id_rs1)
  - raw2 = id_rs2_re & eb(id_rs2)
  - waw = id_rd_we & eb(id_rd)
- stall = id_valid & ~flush & (raw1 | raw2 | waw).
- bubble = stall.
- issue = id_valid & ~flush & ~stall & id_rd_we & (id_rd != 0) & (id_load | id_long).
- Sequential update, per entry, at each clk edge:
  - Issue to r: busy = 1. If load: lng = 0, cnt = LOAD_LAT. If long: lng = 1, cnt unchanged.
  - Else, load entry (busy & ~lng): if cnt == 1, busy = 0 and cnt = 0; else cnt decrements.
  - Else, long entry: if wb_valid & wb_rd == r, clear busy and lng.
  - Issue to r has priority over a same-cycle decrement or writeback clear of r.
- Timing:
  - A load rd is busy for exactly LOAD_LAT cycles after the issue edge. The dependent instruction therefore sees LOAD_LAT bubbles.
  - With WB_BYPASS = 0, a long-op consumer stalls through the writeback cycle, i.e. one extra bubble.
- Ignored writebacks: wb_valid for a register that is not a long entry, or for wb_rd = 0, is ignored.
- Flush:
  - gates both stall and issue in the current cycle;
  - does not clear existing entries, since they belong to older, committed instructions.
- long_pending = OR over r of (busy[r] & lng[r]), from registered state.
- stall_cnt increments by 1 on each edge where stall = 1; it holds at 2^CNT_W - 1.
- Reset mid-operation: all entries are dropped on that edge; the next cycle shows no stall even if a long op was outstanding.
- Addresses with id_rs*/id_rd >= REG_NUM are treated as not busy.

Test Plan:
- Load-use, LOAD_LAT = 1:
  - Stimulus: cycle 0 issue load rd = 5; cycle 1 ID reads rs1 = 5.
  - Required: stall = 1 in cycle 1 only; cycle 2 stall = 0 and issue proceeds; stall_cnt = 1.
- LOAD_LAT = 3: load rd = 7, then a consumer rs2 = 7 is held in ID.
  - Required: stall for 3 consecutive cycles, then released; stall_cnt = 3.
- False-hazard suppression:
  - Stimulus: load rd = 0, then rs1 = 0. Separately, load rd = 4 followed by rs2 = 4 with rs2_re = 0.
  - Required: stall = 0 throughout.
- Long op, WB_BYPASS = 1:
  - Stimulus: DIV rd = 9 issued; consumer rs1 = 9 waits; wb_valid with wb_rd = 9 at cycle 12.
  - Required: stall = 1 for cycles 1..11, 0 at cycle 12; long_pending falls after the cycle 12 edge.
  - Repeat with WB_BYPASS = 0: stall additionally asserted in cycle 12.
- WAW and flush:
  - WAW: with DIV rd = 3 pending, a load rd = 3 stalls.
  - Flush: assert flush in a stall cycle. Required: stall = 0, no issue, and entry 3 remains busy.
- Reset and saturation:
  - Reset: rst during a pending DIV. Required: long_pending = 0 and stall = 0 on the next cycle.
  - Saturation, with CNT_W = 4: hold 20 stall cycles. Required: stall_cnt = 15.
